process_scheduler: RTL and testbench

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

---
 rtl/process_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_process_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: keeps per-slot state and saved PC, dispatches
// READY slots to the processor and saves context on preemption or program end.
module process_scheduler #(
   parameter int NUM_PROC    = 8,
   parameter int BASE_OFFSET = 200,
   parameter int QUANTUM     = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        create_valid,
   input  logic [2:0]  create_pid,
   input  logic [31:0] create_pc,
   input  logic        trap_valid,
   input  logic        trap_end,
   input  logic [31:0] trap_pc,
   output logic        trap_ready,
   output logic        dispatch_valid,
   input  logic        dispatch_ready,
   output logic [2:0]  dispatch_pid,
   output logic [31:0] dispatch_pc,
   output logic [31:0] dispatch_quantum,
   output logic [2:0]  cur_pid,
   output logic        idle,
   output logic        create_err,
   output logic [3:0]  ready_count
);

   localparam int PW = 3;
   localparam logic [3:0] MAX_PID = 4'(NUM_PROC - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SAVE     = 3'd1,
      ST_SELECT   = 3'd2,
      ST_DISPATCH = 3'd3,
      ST_RUN      = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      SLOT_EMPTY   = 2'd0,
      SLOT_READY   = 2'd1,
      SLOT_RUNNING = 2'd2
   } slot_t;

   state_t        state_r, state_nxt_s;
   slot_t         slot_state_r [NUM_PROC];
   logic [31:0]   slot_pc_r    [NUM_PROC];
   logic [PW-1:0] cur_pid_r, last_pid_r, dispatch_pid_r, sel_pid_s;
   logic [31:0]   dispatch_pc_r, dispatch_quantum_r, trap_pc_r, save_pc_s;
   logic [3:0]    ready_count_r, ready_count_s, sel_base_s, sel_sum_s, sel_cand_s;
   logic          trap_end_r, dispatch_valid_r, trap_ready_r, idle_r, create_err_r;
   logic          sel_found_s, trap_accept_s, dispatch_fire_s, save_s, select_load_s;
   logic          create_hit_s;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:     state_nxt_s = (ready_count_r != 4'd0) ? ST_SELECT : ST_IDLE;
         ST_SAVE:     state_nxt_s = ST_SELECT;
         ST_SELECT:   state_nxt_s = sel_found_s ? ST_DISPATCH : ST_IDLE;
         ST_DISPATCH: state_nxt_s = dispatch_ready ? ST_RUN : ST_DISPATCH;
         ST_RUN:      state_nxt_s = trap_valid ? ST_SAVE : ST_RUN;
         default:     state_nxt_s = ST_IDLE;
      endcase
   end

   // Per-state action strobes
   always_comb begin
      trap_accept_s   = (state_r == ST_RUN) && trap_valid;
      dispatch_fire_s = (state_r == ST_DISPATCH) && dispatch_ready;
      save_s          = (state_r == ST_SAVE);
      select_load_s   = (state_r == ST_SELECT) && sel_found_s;
   end

   // Round-robin scan starting just after the last dispatched pid; that pid comes last
   always_comb begin
      sel_found_s = 1'b0;
      sel_pid_s   = 3'd0;
      sel_sum_s   = 4'd0;
      sel_cand_s  = 4'd0;
      sel_base_s  = (last_pid_r == 3'd0) ? MAX_PID : {1'b0, last_pid_r};
      for (int i = 1; i < NUM_PROC; i++) begin
         sel_sum_s  = sel_base_s + 4'(i);
         sel_cand_s = (sel_sum_s > MAX_PID) ? (sel_sum_s - MAX_PID) : sel_sum_s;
         if (!sel_found_s && (slot_state_r[sel_cand_s[PW-1:0]] == SLOT_READY)) begin
            sel_found_s = 1'b1;
            sel_pid_s   = sel_cand_s[PW-1:0];
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // READY population and create acceptance, both from registered slot state
   always_comb begin
      ready_count_s = 4'd0;
      for (int p = 1; p < NUM_PROC; p++) begin
         if (slot_state_r[PW'(p)] == SLOT_READY) begin
            ready_count_s = ready_count_s + 4'd1;
         end else begin
            ready_count_s = ready_count_s;
         end
      end
      save_pc_s    = trap_pc_r - (32'(cur_pid_r) * 32'(BASE_OFFSET));
      create_hit_s = create_valid && (create_pid != 3'd0) && ({1'b0, create_pid} <= MAX_PID)
                     && (slot_state_r[create_pid] == SLOT_EMPTY)
                     && !(save_s && (create_pid == cur_pid_r));
   end

   // Datapath: slot table, dispatch registers and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int p = 0; p < NUM_PROC; p++) begin
            slot_state_r[PW'(p)] <= SLOT_EMPTY;
            slot_pc_r[PW'(p)]    <= 32'd0;
         end
         cur_pid_r          <= 3'd0;
         last_pid_r         <= 3'd0;
         dispatch_pid_r     <= 3'd0;
         dispatch_pc_r      <= 32'd0;
         dispatch_quantum_r <= 32'(QUANTUM);
         trap_end_r         <= 1'b0;
         trap_pc_r          <= 32'd0;
         ready_count_r      <= 4'd0;
         create_err_r       <= 1'b0;
         dispatch_valid_r   <= 1'b0;
         trap_ready_r       <= 1'b0;
         idle_r             <= 1'b1;
      end else begin
         if (trap_accept_s) begin
            trap_end_r <= trap_end;
            trap_pc_r  <= trap_pc;
         end
         // SAVE outranks a create on the same slot; create_hit_s already excludes that case
         for (int p = 1; p < NUM_PROC; p++) begin
            if (save_s && (cur_pid_r == PW'(p))) begin
               slot_state_r[PW'(p)] <= trap_end_r ? SLOT_EMPTY : SLOT_READY;
               if (!trap_end_r) begin
                  slot_pc_r[PW'(p)] <= save_pc_s;
               end
            end else if (dispatch_fire_s && (dispatch_pid_r == PW'(p))) begin
               slot_state_r[PW'(p)] <= SLOT_RUNNING;
            end else if (create_hit_s && (create_pid == PW'(p))) begin
               slot_state_r[PW'(p)] <= SLOT_READY;
               slot_pc_r[PW'(p)]    <= create_pc;
            end
         end
         if (save_s) begin
            cur_pid_r <= 3'd0;
         end else if (dispatch_fire_s) begin
            cur_pid_r  <= dispatch_pid_r;
            last_pid_r <= dispatch_pid_r;
         end
         if (select_load_s) begin
            dispatch_pid_r     <= sel_pid_s;
            dispatch_pc_r      <= slot_pc_r[sel_pid_s];
            dispatch_quantum_r <= 32'(QUANTUM);
         end
         ready_count_r    <= ready_count_s;
         create_err_r     <= create_valid && !create_hit_s;
         dispatch_valid_r <= (state_nxt_s == ST_DISPATCH);
         trap_ready_r     <= (state_nxt_s == ST_RUN);
         idle_r           <= (state_nxt_s == ST_IDLE);
      end
   end

   assign trap_ready       = trap_ready_r;
   assign dispatch_valid   = dispatch_valid_r;
   assign dispatch_pid     = dispatch_pid_r;
   assign dispatch_pc      = dispatch_pc_r;
   assign dispatch_quantum = dispatch_quantum_r;
   assign cur_pid          = cur_pid_r;
   assign idle             = idle_r;
   assign create_err       = create_err_r;
   assign ready_count      = ready_count_r;

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: expected dispatches are queued by the
// stimulus and checked by a monitor on each dispatch handshake.
module tb_process_scheduler;

   logic        clock = 1'b0;
   logic        reset, create_valid, trap_valid, trap_end, dispatch_ready;
   logic [2:0]  create_pid;
   logic [31:0] create_pc, trap_pc;
   logic        trap_ready, dispatch_valid, idle, create_err;
   logic [2:0]  dispatch_pid, cur_pid;
   logic [31:0] dispatch_pc, dispatch_quantum;
   logic [3:0]  ready_count;

   typedef struct { logic [2:0] pid; logic [31:0] pc; } disp_t;
   disp_t exp_q [$];

   int checks = 0;
   int fails  = 0;

   process_scheduler dut (
      .clock(clock), .reset(reset),
      .create_valid(create_valid), .create_pid(create_pid), .create_pc(create_pc),
      .trap_valid(trap_valid), .trap_end(trap_end), .trap_pc(trap_pc),
      .trap_ready(trap_ready), .dispatch_valid(dispatch_valid),
      .dispatch_ready(dispatch_ready), .dispatch_pid(dispatch_pid),
      .dispatch_pc(dispatch_pc), .dispatch_quantum(dispatch_quantum),
      .cur_pid(cur_pid), .idle(idle), .create_err(create_err),
      .ready_count(ready_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [2:0] pid, input logic [31:0] pc);
      disp_t d;
      d.pid = pid;
      d.pc  = pc;
      exp_q.push_back(d);
   endtask

   task automatic do_create(input logic [2:0] pid, input logic [31:0] pc);
      create_valid = 1'b1;
      create_pid   = pid;
      create_pc    = pc;
      tick(1);
      create_valid = 1'b0;
   endtask

   task automatic wait_dispatch();
      int n = 0;
      while (dispatch_valid !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      check("dispatch_timeout", 32'(dispatch_valid), 32'd1);
   endtask

   task automatic handshake();
      dispatch_ready = 1'b1;
      tick(1);
      dispatch_ready = 1'b0;
   endtask

   task automatic do_trap(input logic e, input logic [31:0] pc);
      check("trap_ready_before_trap", 32'(trap_ready), 32'd1);
      trap_valid = 1'b1;
      trap_end   = e;
      trap_pc    = pc;
      tick(1);
      trap_valid = 1'b0;
   endtask

   // Monitor: every accepted dispatch must match the head of the scoreboard
   always @(negedge clock) begin
      if (reset === 1'b0 && dispatch_valid === 1'b1 && dispatch_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_dispatch: pid %0d pc %0d with empty scoreboard", dispatch_pid, dispatch_pc);
         end else begin
            disp_t d;
            d = exp_q.pop_front();
            check("disp_pid", 32'(dispatch_pid), 32'(d.pid));
            check("disp_pc", dispatch_pc, d.pc);
            check("disp_quantum", dispatch_quantum, 32'd10);
         end
      end
   end

   initial begin
      reset = 1'b1; create_valid = 1'b0; create_pid = 3'd0; create_pc = 32'd0;
      trap_valid = 1'b0; trap_end = 1'b0; trap_pc = 32'd0; dispatch_ready = 1'b0;
      tick(2);
      reset = 1'b0;
      check("rst_dispatch_valid", 32'(dispatch_valid), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_trap_ready", 32'(trap_ready), 32'd0);
      check("rst_cur_pid", 32'(cur_pid), 32'd0);
      check("rst_ready_count", 32'(ready_count), 32'd0);
      check("rst_create_err", 32'(create_err), 32'd0);
      check("rst_quantum", dispatch_quantum, 32'd10);
      check("rst_dispatch_pid", 32'(dispatch_pid), 32'd0);
      check("rst_dispatch_pc", dispatch_pc, 32'd0);

      // Cold start
      push(3'd2, 32'd5);
      do_create(3'd2, 32'd5);
      check("cold_create_err", 32'(create_err), 32'd0);
      tick(1);
      check("cold_ready_count", 32'(ready_count), 32'd1);
      wait_dispatch();
      handshake();
      check("cold_cur_pid", 32'(cur_pid), 32'd2);
      check("cold_idle", 32'(idle), 32'd0);
      check("cold_trap_ready", 32'(trap_ready), 32'd1);

      // Rejected creates: pid 0, then the RUNNING slot
      do_create(3'd0, 32'd1);
      check("err_pid0", 32'(create_err), 32'd1);
      tick(1);
      check("err_pulse_clear", 32'(create_err), 32'd0);
      do_create(3'd2, 32'd9);
      check("err_running", 32'(create_err), 32'd1);
      tick(1);
      check("err_running_count", 32'(ready_count), 32'd0);
      check("err_running_cur", 32'(cur_pid), 32'd2);

      // Program end on the only process
      do_trap(1'b1, 32'd405);
      tick(2);
      check("end_idle", 32'(idle), 32'd1);
      check("end_ready_count", 32'(ready_count), 32'd0);
      check("end_cur_pid", 32'(cur_pid), 32'd0);
      check("end_dispatch_valid", 32'(dispatch_valid), 32'd0);

      // Round robin after last pid 2: 3 is chosen before 1
      push(3'd3, 32'd30);
      do_create(3'd1, 32'd7);
      do_create(3'd3, 32'd30);
      wait_dispatch();
      handshake();
      push(3'd1, 32'd7);
      do_trap(1'b0, 32'd640);
      check("lat_save_valid", 32'(dispatch_valid), 32'd0);
      tick(1);
      check("lat_select_valid", 32'(dispatch_valid), 32'd0);
      tick(1);
      check("lat_dispatch_valid", 32'(dispatch_valid), 32'd1);
      handshake();

      // Preempt pid 1 at absolute 212 -> saved 12; pid 3 resumes at 40
      push(3'd3, 32'd40);
      do_trap(1'b0, 32'd212);
      wait_dispatch();
      handshake();
      push(3'd1, 32'd12);
      do_trap(1'b0, 32'd645);
      wait_dispatch();
      // Backpressure with a stray trap_valid outside RUN
      trap_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 32'(dispatch_valid), 32'd1);
         check("bp_pid", 32'(dispatch_pid), 32'd1);
         check("bp_pc", dispatch_pc, 32'd12);
         check("bp_trap_ready", 32'(trap_ready), 32'd0);
         tick(1);
      end
      trap_valid = 1'b0;
      handshake();

      // Create on pid 1 collides with its SAVE: saved PC 50 wins
      push(3'd3, 32'd45);
      do_trap(1'b0, 32'd250);
      do_create(3'd1, 32'd999);
      check("collide_err", 32'(create_err), 32'd1);
      wait_dispatch();
      handshake();
      push(3'd1, 32'd50);
      do_trap(1'b0, 32'd700);
      wait_dispatch();
      handshake();

      // Reset while pid 3 (PC 100) is being offered
      do_trap(1'b0, 32'd210);
      wait_dispatch();
      check("pre_reset_pid", 32'(dispatch_pid), 32'd3);
      check("pre_reset_pc", dispatch_pc, 32'd100);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      exp_q.delete();
      check("mid_rst_valid", 32'(dispatch_valid), 32'd0);
      check("mid_rst_idle", 32'(idle), 32'd1);
      check("mid_rst_count", 32'(ready_count), 32'd0);
      check("mid_rst_cur", 32'(cur_pid), 32'd0);
      tick(5);
      check("post_rst_valid", 32'(dispatch_valid), 32'd0);
      check("post_rst_count", 32'(ready_count), 32'd0);
      do_create(3'd1, 32'd3);
      check("post_rst_create1", 32'(create_err), 32'd0);
      do_create(3'd3, 32'd4);
      check("post_rst_create3", 32'(create_err), 32'd0);
      tick(1);
      check("post_rst_ready2", 32'(ready_count), 32'd2);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
